// File: rtl/vga_receiver.sv
`default_nettype none
// ============================================================================
// Module   : vga_receiver
// Purpose  : Recovers VGA timing from active-low syncs, locks onto the frame
//            structure and emits registered pixel coordinates and colour.
// Revision : 1.0 - initial release
// ============================================================================
module vga_receiver #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk_25_175_i,
  input  logic        rst_ni,
  input  logic        vga_hsync_i,
  input  logic        vga_vsync_i,
  input  logic [3:0]  vga_red_i,
  input  logic [3:0]  vga_green_i,
  input  logic [3:0]  vga_blue_i,
  output logic        locked_o,
  output logic        pixel_valid_o,
  output logic [9:0]  position_x_o,
  output logic [9:0]  position_y_o,
  output logic [3:0]  red_o,
  output logic [3:0]  green_o,
  output logic [3:0]  blue_o,
  output logic        frame_start_o,
  output logic [15:0] frame_count_o,
  output logic [7:0]  lock_loss_count_o
);

  localparam int c_h_sum = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_sum = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] c_h_last = 10'(c_h_sum - 1);
  localparam logic [9:0] c_h_over = 10'(c_h_sum);
  localparam logic [9:0] c_v_last = 10'(c_v_sum);
  localparam logic [9:0] c_v_over = 10'(c_v_sum + 1);
  localparam logic [9:0] c_x_lo   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] c_x_hi   = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] c_y_lo   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] c_y_hi   = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_hs_s1, r_vs_s1, r_hs_d, r_vs_d;
  logic [3:0]  r_red_s1, r_green_s1, r_blue_s1;
  logic [9:0]  r_h_cnt, r_v_cnt;
  logic        r_h_seen;
  logic        r_locked, r_frame_start, r_pixel_valid;
  logic [15:0] r_frame_count;
  logic [7:0]  r_loss_count;
  logic [9:0]  r_pos_x, r_pos_y;
  logic [3:0]  r_red, r_green, r_blue;

  logic w_hs_edge, w_vs_edge, w_line_err, w_frame_err, w_err, w_in_window;

  assign w_hs_edge   = r_hs_d & ~r_hs_s1;
  assign w_vs_edge   = r_vs_d & ~r_vs_s1;
  // Line length is meaningless until the counter has been aligned once.
  assign w_line_err  = r_h_seen & ((w_hs_edge & (r_h_cnt != c_h_last)) | (r_h_cnt == c_h_over));
  assign w_frame_err = (w_vs_edge & (r_v_cnt != c_v_last)) | (r_v_cnt == c_v_over);
  assign w_err       = w_line_err | w_frame_err;
  assign w_in_window = (r_h_cnt >= c_x_lo) && (r_h_cnt <= c_x_hi) &&
                       (r_v_cnt >= c_y_lo) && (r_v_cnt <= c_y_hi);

  always_ff @(posedge clk_25_175_i) begin
    if (!rst_ni) begin
      r_hs_s1    <= 1'b1;
      r_vs_s1    <= 1'b1;
      r_hs_d     <= 1'b1;
      r_vs_d     <= 1'b1;
      r_red_s1   <= 4'd0;
      r_green_s1 <= 4'd0;
      r_blue_s1  <= 4'd0;
    end else begin
      r_hs_s1    <= vga_hsync_i;
      r_vs_s1    <= vga_vsync_i;
      r_hs_d     <= r_hs_s1;
      r_vs_d     <= r_vs_s1;
      r_red_s1   <= vga_red_i;
      r_green_s1 <= vga_green_i;
      r_blue_s1  <= vga_blue_i;
    end
  end

  always_ff @(posedge clk_25_175_i) begin
    if (!rst_ni) begin
      r_h_cnt  <= 10'd0;
      r_v_cnt  <= 10'd0;
      r_h_seen <= 1'b0;
    end else begin
      if (w_hs_edge) begin
        r_h_cnt <= 10'd0;
      end else if (r_h_cnt != 10'h3FF) begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
      // A vsync edge landing on a line start already counts that line.
      if (w_vs_edge) begin
        r_v_cnt <= w_hs_edge ? 10'd1 : 10'd0;
      end else if (w_hs_edge) begin
        r_v_cnt <= r_v_cnt + 10'd1;
      end
      r_h_seen <= r_h_seen | w_hs_edge;
    end
  end

  always_ff @(posedge clk_25_175_i) begin
    if (!rst_ni) begin
      r_state       <= SEARCH;
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 16'd0;
      r_loss_count  <= 8'd0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        SEARCH: begin
          if (w_vs_edge) r_state <= ALIGN;
        end
        ALIGN: begin
          if (w_err) begin
            r_state <= SEARCH;
          end else if (w_vs_edge) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (w_err) begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
            if (r_loss_count != 8'hFF) r_loss_count <= r_loss_count + 8'd1;
          end else if (w_vs_edge) begin
            r_frame_start <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_25_175_i) begin
    if (!rst_ni || !((r_state == LOCKED) && w_in_window)) begin
      r_pixel_valid <= 1'b0;
      r_pos_x       <= 10'd0;
      r_pos_y       <= 10'd0;
      r_red         <= 4'd0;
      r_green       <= 4'd0;
      r_blue        <= 4'd0;
    end else begin
      r_pixel_valid <= 1'b1;
      r_pos_x       <= r_h_cnt - c_x_lo;
      r_pos_y       <= r_v_cnt - c_y_lo;
      r_red         <= r_red_s1;
      r_green       <= r_green_s1;
      r_blue        <= r_blue_s1;
    end
  end

  assign locked_o          = r_locked;
  assign pixel_valid_o     = r_pixel_valid;
  assign position_x_o      = r_pos_x;
  assign position_y_o      = r_pos_y;
  assign red_o             = r_red;
  assign green_o           = r_green;
  assign blue_o            = r_blue;
  assign frame_start_o     = r_frame_start;
  assign frame_count_o     = r_frame_count;
  assign lock_loss_count_o = r_loss_count;

endmodule
`default_nettype wire
